// File: rtl/conv_window_buffer_if.sv
// Stream bundle for conv_window_buffer: raster pixel input and 5x5 window output.
// The design takes the slave side; the pixel source / window sink takes the master side.
interface conv_window_buffer_if #(
    parameter int bitwidth = 32
);
    logic                                in_valid;
    logic                                in_ready;
    logic signed [bitwidth-1:0]          in_pixel;
    logic        [4:0][4:0][bitwidth-1:0] map_block;
    logic                                out_valid;
    logic                                out_ready;
    logic                                frame_last;

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, map_block, out_valid, frame_last
    );

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, map_block, out_valid, frame_last
    );
endinterface

// File: rtl/conv_window_buffer.sv
// Streaming 5x5 stride-1 window generator over a raster pixel stream, 4 line buffers deep.
// Optional status outputs (window_count, overrun) are built when CONV_WINDOW_STATUS_EN is defined.
//
// Handshake: a pixel moves when in_valid & in_ready, a window moves when out_valid & out_ready;
// in_ready = !out_valid | out_ready, so the output register is the only storage stage.
module conv_window_buffer #(
    parameter int bitwidth   = 32,
    parameter int MAP_WIDTH  = 32,
    parameter int MAP_HEIGHT = 32
) (
    input  logic                clk,
    input  logic                rst,
    conv_window_buffer_if.slave bus,
    output logic [1:0]          o_dbg_state
`ifdef CONV_WINDOW_STATUS_EN
    ,
    output logic [31:0]         window_count,
    output logic                overrun
`endif
);

    localparam int CW = $clog2(MAP_WIDTH);
    localparam int RW = $clog2(MAP_HEIGHT);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_EMIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_next_state;
    logic [CW-1:0]                   r_col;
    logic [RW-1:0]                   r_row;
    logic                            r_frame_last;
    logic [4:0][4:0][bitwidth-1:0]   r_win;
    logic [bitwidth-1:0]             r_lb [4][MAP_WIDTH];
    logic [4:0][bitwidth-1:0]        w_new_col;
    logic                            w_out_valid;
    logic                            w_in_ready;
    logic                            w_frame_last;
    logic                            w_pix_acc;
    logic                            w_win_acc;
    logic                            w_col_last;
    logic                            w_row_last;
    logic                            w_in_window;

    assign w_pix_acc   = bus.in_valid & w_in_ready;
    assign w_win_acc   = w_out_valid & bus.out_ready;
    assign w_col_last  = (r_col == CW'(MAP_WIDTH - 1));
    assign w_row_last  = (r_row == RW'(MAP_HEIGHT - 1));
    assign w_in_window = (r_row >= RW'(4)) && (r_col >= CW'(4));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FILL;
        else     r_state <= w_next_state;
    end

    // Each accepted pixel decides the next state from its own coordinates.
    always_comb begin
        w_next_state = r_state;
        if (w_pix_acc)
            w_next_state = w_in_window ? S_EMIT : S_FILL;
        else if (r_state != S_FILL)
            w_next_state = bus.out_ready ? S_FILL : S_HOLD;
    end

    always_comb begin
        w_out_valid  = (r_state != S_FILL);
        w_in_ready   = !w_out_valid || bus.out_ready;
        w_frame_last = r_frame_last && w_out_valid;
    end

    assign bus.out_valid  = w_out_valid;
    assign bus.in_ready   = w_in_ready;
    assign bus.frame_last = w_frame_last;
    assign bus.map_block  = r_win;
    assign o_dbg_state    = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_frame_last <= 1'b0;
        end else if (w_pix_acc) begin
            r_frame_last <= w_row_last && w_col_last;
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) w_new_col[i] = r_lb[i][r_col];
        w_new_col[4] = bus.in_pixel;
    end

    // Line buffers are never cleared: every word is rewritten before it reaches a window.
    always_ff @(posedge clk) begin
        if (w_pix_acc) begin
            for (int k = 0; k < 3; k++) r_lb[k][r_col] <= r_lb[k+1][r_col];
            r_lb[3][r_col] <= bus.in_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win <= '0;
        end else if (w_pix_acc) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 4; j++) r_win[i][j] <= r_win[i][j+1];
                r_win[i][4] <= w_new_col[i];
            end
        end
    end

`ifdef CONV_WINDOW_STATUS_EN
    localparam int SW = $clog2(MAP_WIDTH + 1);

    logic [SW-1:0] r_stall_cnt;
    logic          r_clr_pending;
    logic [31:0]   r_window_count;
    logic          r_overrun;
    logic          w_stall;

    assign w_stall = bus.in_valid & ~w_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_window_count <= '0;
            r_clr_pending  <= 1'b0;
        end else begin
            r_clr_pending <= w_win_acc && w_frame_last;
            if (r_clr_pending)
                r_window_count <= w_win_acc ? 32'd1 : 32'd0;
            else if (w_win_acc)
                r_window_count <= r_window_count + 32'd1;
        end
    end

    // Overrun flags a stalled source that has been held off for more than a full row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_overrun   <= 1'b0;
        end else if (w_stall) begin
            if (r_stall_cnt == SW'(MAP_WIDTH)) r_overrun <= 1'b1;
            else                               r_stall_cnt <= r_stall_cnt + 1'b1;
        end else begin
            r_stall_cnt <= '0;
        end
    end

    assign window_count = r_window_count;
    assign overrun      = r_overrun;
`else
    logic w_unused;
    assign w_unused = w_win_acc;
`endif

endmodule

// File: tb/tb_conv_window_buffer.sv
// Randomized bench for conv_window_buffer: a frame-array reference model builds each
// expected window from the pixels it has accepted and a scoreboard queue checks the DUT.
module tb_conv_window_buffer;
    localparam int BW   = 32;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int WINW = 25 * BW + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_window_buffer_if #(.bitwidth(BW)) bus ();
    logic [1:0] dbg_state;
`ifdef CONV_WINDOW_STATUS_EN
    logic [31:0] window_count;
    logic        overrun;
`endif

    conv_window_buffer #(
        .bitwidth(BW), .MAP_WIDTH(W), .MAP_HEIGHT(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .o_dbg_state(dbg_state)
`ifdef CONV_WINDOW_STATUS_EN
        ,
        .window_count(window_count),
        .overrun(overrun)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [WINW-1:0] exp_q[$];
    logic [BW-1:0]   frame [H][W];
    int  m_row, m_col, m_pix;
    bit  m_ov;
    int  run_wins, run_fls, frame_wins;
    int  m_wc, m_stall;
    bit  m_clr, m_ovr;

    task automatic check(input string tag, input logic [831:0] got, input logic [831:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_row = 0; m_col = 0; m_ov = 0;
        frame_wins = 0;
        m_wc = 0; m_clr = 0; m_stall = 0; m_ovr = 0;
    endtask

    function automatic logic [BW-1:0] pix_value(input int mode, input int r, input int c);
        case (mode)
            0:       return BW'(r * 8 + c);
            1:       return BW'(-(r * 8 + c));
            default: return $urandom;
        endcase
    endfunction

    // Window ending at (r,c): element [i][j] is the frame pixel (r-4+i, c-4+j); top bit = frame end.
    function automatic logic [WINW-1:0] make_window(input int r, input int c);
        logic [WINW-1:0] w;
        w = '0;
        w[WINW-1] = (r == H - 1) && (c == W - 1);
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                w[(i*5+j)*BW +: BW] = frame[r-4+i][c-4+j];
        return w;
    endfunction

    // Drive one cycle at the falling edge, check outputs, then advance the model.
    task automatic cycle(input bit v, input logic [BW-1:0] px, input bit ordy, input int mode);
        bit pix_acc, win_acc, in_win;
        logic [WINW-1:0] head;
        bus.in_valid  = v;
        bus.in_pixel  = px;
        bus.out_ready = ordy;
        #1;
        head = (exp_q.size() != 0) ? exp_q[0] : '0;
        check("out_valid", bus.out_valid, m_ov);
        check("in_ready", bus.in_ready, !m_ov || ordy);
        check("frame_last", bus.frame_last, m_ov && head[WINW-1]);
        if (m_ov) check("map_block", bus.map_block, head[WINW-2:0]);
        pix_acc = v && (!m_ov || ordy);
        win_acc = m_ov && ordy;
        in_win  = 0;
`ifdef CONV_WINDOW_STATUS_EN
        check("window_count", window_count, m_wc);
        check("overrun", overrun, m_ovr);
        if (m_clr) check("window_count_at_last", window_count, (W - 4) * (H - 4));
        if (m_clr) m_wc = win_acc ? 1 : 0;
        else       m_wc = m_wc + int'(win_acc);
        m_clr = win_acc && head[WINW-1];
        if (v && m_ov && !ordy) begin
            m_stall++;
            if (m_stall > W) m_ovr = 1;
        end else begin
            m_stall = 0;
        end
`endif
        if (win_acc) begin
            if (mode == 0 && frame_wins == 0) begin
                check("first_00", bus.map_block[0][0], 0);
                check("first_44", bus.map_block[4][4], 36);
                check("first_23", bus.map_block[2][3], 19);
            end
            if (mode == 1 && frame_wins == 0) check("neg_first_44", bus.map_block[4][4], 32'hFFFF_FFDC);
            if (mode == 0 && head[WINW-1]) begin
                check("last_44", bus.map_block[4][4], 63);
                check("last_00", bus.map_block[0][0], 27);
            end
            void'(exp_q.pop_front());
            run_wins++;
            frame_wins++;
            if (head[WINW-1]) begin
                run_fls++;
                frame_wins = 0;
            end
        end
        if (pix_acc) begin
            frame[m_row][m_col] = px;
            in_win = (m_row >= 4) && (m_col >= 4);
            if (in_win) exp_q.push_back(make_window(m_row, m_col));
            m_pix++;
            if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
        m_ov = pix_acc ? in_win : (m_ov && !ordy);
        @(negedge clk);
    endtask

    task automatic run(input int npix, input int mode, input int gap_pct, input int bp_pct,
                       input int hold_win, input bit drain);
        int cyc = 0;
        int hold_left = 3;
        bit v, ordy;
        m_pix = 0; run_wins = 0; run_fls = 0;
        while (m_pix < npix && cyc < 20000) begin
            v    = ($urandom_range(99) >= gap_pct);
            ordy = ($urandom_range(99) >= bp_pct);
            if (hold_win > 0 && m_ov && run_wins == hold_win - 1 && hold_left > 0) begin
                ordy = 0;
                hold_left--;
            end
            cycle(v, pix_value(mode, m_row, m_col), ordy, mode);
            cyc++;
        end
        check("feed_timeout", m_pix >= npix, 1);
        if (drain) begin
            cyc = 0;
            while ((m_ov || exp_q.size() != 0) && cyc < 200) begin
                cycle(0, '0, 1, mode);
                cyc++;
            end
            check("drain_timeout", m_ov || exp_q.size() != 0, 0);
        end
    endtask

    task automatic reset_mid(input int npix);
        run(npix, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_frame_last", bus.frame_last, 0);
        check("rst_map_block", bus.map_block, 0);
        check("rst_in_ready", bus.in_ready, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_pixel  = '0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_map_block", bus.map_block, 0);
        check("reset_frame_last", bus.frame_last, 0);
        check("reset_state", dbg_state, 0);
        rst = 1'b0;

        run(64, 0, 0, 0, 0, 1);
        check("full_rate_windows", run_wins, 16);
        check("full_rate_frame_last", run_fls, 1);

        run(64, 0, 0, 0, 5, 1);
        check("hold_windows", run_wins, 16);
        check("hold_frame_last", run_fls, 1);

        reset_mid(20);
        run(64, 0, 0, 0, 0, 1);
        check("after_rst20_windows", run_wins, 16);

        reset_mid(45);
        run(64, 0, 20, 20, 0, 1);
        check("after_rst45_windows", run_wins, 16);
        check("after_rst45_frame_last", run_fls, 1);

        run(128, 1, 30, 30, 0, 1);
        check("neg_windows", run_wins, 32);
        check("neg_frame_last", run_fls, 2);

        run(192, 2, 25, 35, 0, 1);
        check("rand_windows", run_wins, 48);
        check("rand_frame_last", run_fls, 3);

`ifdef CONV_WINDOW_STATUS_EN
        run(37, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) cycle(1, pix_value(0, m_row, m_col), 0, 0);
        check("overrun_set", overrun, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
